image_loader: RTL and testbench

Upstream stage of the SNN core: consumes bytes from the UART receiver, unpacks each byte LSB-first into the 1-bit-wide input image RAM (784 bits = 98 bytes), then pulses `start` to the core and holds off new frames until the core reports `done`. It sits between the UART RX and the input-RAM/`snn_core` pair. It also provides inter-byte timeout resynchronisation and overrun/drop reporting.

---
 rtl/snn_pkg.sv | 17 +
 rtl/image_loader_if.sv | 31 +++
 rtl/image_loader_serializer.sv | 44 ++++
 rtl/image_loader.sv | 186 ++++++++++++++++++
 tb/tb_image_loader.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN input path.
//   loader_state_t : image_loader FSM states
//   IMG_BITS       : pixels per input image (one bit each)
package snn_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    WAIT_BYTE = 3'd2,
    START     = 3'd3,
    RUN       = 3'd4
  } loader_state_t;

  localparam int IMG_BITS      = 784;
  localparam int BITS_PER_BYTE = 8;

endpackage

// File: rtl/image_loader_if.sv
// Signal bundle around image_loader: UART RX byte strobe, input-RAM write
// port, snn_core start/done handshake and status pulses.
//   slave  : the loader side (consumes rx/done, drives RAM and status)
//   master : the environment side (UART RX, RAM, snn_core)
interface image_loader_if #(
  parameter int ADDR_W = 10
);
  import snn_pkg::*;

  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wdata;
  logic              start;
  logic              done;
  logic              busy;
  logic              frame_err;
  logic              overrun;

  modport slave (
    input  rx_rdy, rx_data, done,
    output ram_we, ram_addr, ram_wdata, start, busy, frame_err, overrun
  );

  modport master (
    output rx_rdy, rx_data, done,
    input  ram_we, ram_addr, ram_wdata, start, busy, frame_err, overrun
  );

endinterface

// File: rtl/image_loader_serializer.sv
// byte_serializer: 8-bit shift register with a 3-bit bit counter.
//   clk, rst : system clock, async active-high reset
//   load     : capture data, bit counter -> 0 (priority over shift)
//   shift    : move to the next bit, bit counter + 1
//   data     : byte to serialize
//   bit_out  : current bit (registered)
//   bit_cnt  : index of the current bit
//   last     : current bit is bit 7
module byte_serializer
  import snn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] data,
  output logic       bit_out,
  output logic [2:0] bit_cnt,
  output logic       last
);

  logic [7:0] sh;
  logic [2:0] cnt;

  // Zero-fill on shift: once a byte has been fully shifted out the register
  // reads 0, so bit_out is already 0 whenever no write is in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      sh  <= data;
      cnt <= '0;
    end else if (shift) begin
      sh  <= {1'b0, sh[7:1]};
      cnt <= cnt + 3'd1;
    end
  end

  assign bit_out = sh[0];
  assign bit_cnt = cnt;
  assign last    = (cnt == 3'd7);

endmodule

// File: rtl/image_loader.sv
// image_loader: unpacks UART bytes LSB-first into the 1-bit input-image RAM,
// fires start to snn_core after the last bit and locks out new data until
// done. Aborts a partial frame after TIMEOUT_CYC idle cycles.
//   clk, rst : system clock, async active-high reset
//   bus      : image_loader_if.slave
//     rx_rdy/rx_data    byte strobe and data from UART RX
//     ram_we/addr/wdata input-RAM write port (addr/wdata 0 when idle)
//     start / done      one-cycle handshake with snn_core
//     busy              first byte of a frame until done
//     frame_err         pulse on inter-byte timeout
//     overrun           pulse when a received byte is dropped
//
// state     | meaning
// IDLE      | no frame in progress, byte count 0
// WRITE     | writing bits 0..7 of the current byte
// WAIT_BYTE | partial frame, waiting for the next byte (timeout running)
// START     | start pulse to snn_core
// RUN       | core busy, incoming bytes dropped
module image_loader
  import snn_pkg::*;
#(
  parameter int NUM_BYTES   = 98,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic          clk,
  input  logic          rst,
  image_loader_if.slave bus
);

  localparam int BC_W  = $clog2(NUM_BYTES);
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  loader_state_t state, state_n;
  logic [BC_W-1:0]  byte_cnt, byte_cnt_n;
  logic [TMO_W-1:0] tmo, tmo_n;
  logic [7:0]       holder, holder_n;
  logic             hold_full, hold_full_n;

  logic       ser_load, ser_shift, ser_bit, ser_last;
  logic [2:0] ser_cnt, bit_cnt_n;
  logic       avail, drop, err_n, lockout;
  logic [7:0] src_byte;

  logic              ram_we_q, ram_wdata_unused;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              start_q, busy_q, frame_err_q, overrun_q;

  // A byte arriving this cycle is usable immediately, so an idle FSM starts
  // writing one cycle after rx_rdy and a byte landing on the last bit cycle
  // continues the WRITE without a gap.
  assign avail    = hold_full | bus.rx_rdy;
  assign src_byte = hold_full ? holder : bus.rx_data;
  assign lockout  = (state == START) || (state == RUN);

  byte_serializer u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (ser_load),
    .shift   (ser_shift),
    .data    (src_byte),
    .bit_out (ser_bit),
    .bit_cnt (ser_cnt),
    .last    (ser_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      tmo       <= '0;
      holder    <= '0;
      hold_full <= 1'b0;
    end else begin
      state     <= state_n;
      byte_cnt  <= byte_cnt_n;
      tmo       <= tmo_n;
      holder    <= holder_n;
      hold_full <= hold_full_n;
    end
  end

  always_comb begin
    state_n    = state;
    byte_cnt_n = byte_cnt;
    tmo_n      = tmo;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    err_n      = 1'b0;
    case (state)
      IDLE: begin
        if (avail) begin
          state_n  = WRITE;
          ser_load = 1'b1;
        end
      end
      WRITE: begin
        if (!ser_last) begin
          ser_shift = 1'b1;
        end else if (byte_cnt == BC_W'(NUM_BYTES - 1)) begin
          byte_cnt_n = '0;
          ser_shift  = 1'b1;
          state_n    = START;
        end else begin
          byte_cnt_n = byte_cnt + 1'b1;
          if (avail) begin
            ser_load = 1'b1;
          end else begin
            ser_shift = 1'b1;
            state_n   = WAIT_BYTE;
            tmo_n     = TMO_W'(TIMEOUT_CYC - 1);
          end
        end
      end
      WAIT_BYTE: begin
        // A byte on the expiry cycle wins over the timeout.
        if (avail) begin
          state_n  = WRITE;
          ser_load = 1'b1;
          tmo_n    = '0;
        end else if (tmo == '0) begin
          state_n    = IDLE;
          byte_cnt_n = '0;
          err_n      = 1'b1;
        end else begin
          tmo_n = tmo - 1'b1;
        end
      end
      START: state_n = RUN;
      RUN: begin
        if (bus.done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Holding register: refilled when empty or when the FSM drains it this
  // cycle; a byte taken straight from rx_data never touches it.
  always_comb begin
    holder_n    = holder;
    hold_full_n = hold_full & ~(ser_load & hold_full);
    drop        = 1'b0;
    if (bus.rx_rdy) begin
      if (lockout) begin
        drop = 1'b1;
      end else if (ser_load && !hold_full) begin
        hold_full_n = 1'b0;
      end else if (!hold_full || ser_load) begin
        holder_n    = bus.rx_data;
        hold_full_n = 1'b1;
      end else begin
        drop = 1'b1;
      end
    end
  end

  assign bit_cnt_n        = ser_load ? 3'd0 : ser_cnt + 3'd1;
  assign ram_wdata_unused = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      ram_we_q    <= (state_n == WRITE);
      ram_addr_q  <= (state_n == WRITE) ? ADDR_W'({byte_cnt_n, bit_cnt_n}) : '0;
      start_q     <= (state_n == START);
      busy_q      <= (state_n != IDLE);
      frame_err_q <= err_n;
      overrun_q   <= drop;
    end
  end

  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ser_bit | ram_wdata_unused;
  assign bus.start     = start_q;
  assign bus.busy      = busy_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_image_loader.sv
// Scoreboard bench for image_loader: stimulus pushes the expected RAM writes,
// a negedge monitor pops and compares every write and tracks status pulses.
module tb_image_loader;
  import snn_pkg::*;

  localparam int NUM_BYTES   = 98;
  localparam int ADDR_W      = 10;
  localparam int TIMEOUT_CYC = 50;
  localparam int LAST_ADDR   = NUM_BYTES * 8 - 1;

  typedef struct {
    int   addr;
    logic d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  image_loader_if #(.ADDR_W(ADDR_W)) bus ();

  image_loader #(
    .NUM_BYTES   (NUM_BYTES),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;
  int  pos = 0;
  int  exp_starts = 0;
  int  cyc = 0;
  int  rx_cyc = 0;
  int  ferr_cyc = 0;
  logic ferr_busy = 1'b0;
  int  starts_seen = 0;
  int  ovr_seen = 0;
  int  ferr_seen = 0;
  int  wr_cyc [0:1023];
  logic prev_we = 1'b0;
  int  prev_addr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_we = 1'b0;
    end else begin
      if (bus.rx_rdy) rx_cyc = cyc;
      if (bus.ram_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {54'd0, bus.ram_addr}, 64'hFFFF);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", {54'd0, bus.ram_addr}, e.addr);
          chk("wr_data", {63'd0, bus.ram_wdata}, {63'd0, e.d});
        end
        wr_cyc[bus.ram_addr] = cyc;
      end else begin
        chk("idle_addr_data", {53'd0, bus.ram_addr, bus.ram_wdata}, 64'd0);
      end
      if (bus.start) begin
        starts_seen++;
        chk("start_after_last_write", {63'd0, prev_we && prev_addr == LAST_ADDR}, 64'd1);
      end
      if (bus.overrun) ovr_seen++;
      if (bus.frame_err) begin
        ferr_seen++;
        ferr_cyc  = cyc;
        ferr_busy = bus.busy;
      end
      prev_we   = bus.ram_we;
      prev_addr = int'(bus.ram_addr);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back('{addr: pos * 8 + i, d: b[i]});
    pos++;
    if (pos == NUM_BYTES) begin
      pos = 0;
      exp_starts++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    start_byte(b);
    tick(1);
    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'h00;
  endtask

  task automatic send_drop(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_rdy  = 1'b1;
    tick(1);
    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'h00;
  endtask

  task automatic pulse_done();
    bus.done = 1'b1;
    tick(1);
    bus.done = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    for (int i = 0; i < max_cyc && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    tick(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    bit found;
    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'h00;
    bus.done    = 1'b0;

    // Reset state
    tick(3);
    chk("reset_outputs", {bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.start,
                          bus.busy, bus.frame_err, bus.overrun}, 64'd0);
    rst = 1'b0;
    tick(2);

    // Spurious done in IDLE
    pulse_done();
    tick(2);
    chk("done_in_idle", {61'd0, bus.busy, bus.start, bus.ram_we}, 64'd0);

    // Full frame, byte k = k, spacing 40; spurious done during byte 5
    for (int k = 0; k < NUM_BYTES; k++) begin
      send_byte(8'(k));
      if (k == 5) begin
        tick(2);
        pulse_done();
        tick(1);
        chk("busy_after_done_in_write", {63'd0, bus.busy}, 64'd1);
        tick(35);
      end else begin
        tick(39);
      end
    end
    wait_drain(200);
    chk("frame1_starts", starts_seen, 1);
    chk("frame1_overrun", ovr_seen, 0);
    chk("frame1_frame_err", ferr_seen, 0);
    chk("busy_in_run", {63'd0, bus.busy}, 64'd1);

    // RUN lockout
    for (int k = 0; k < 3; k++) begin
      send_drop(8'hF0 + 8'(k));
      tick(4);
    end
    tick(2);
    chk("run_overruns", ovr_seen, 3);
    chk("busy_still_run", {63'd0, bus.busy}, 64'd1);

    // done, then a byte on the very next cycle
    pulse_done();
    start_byte(8'hC3);
    @(negedge clk);
    chk("busy_after_done", {63'd0, bus.busy}, 64'd0);
    @(posedge clk); #1;
    bus.rx_rdy = 1'b0;
    tick(20);
    chk("first_write_latency", wr_cyc[0] - rx_cyc, 1);

    // Back-to-back (held byte), then byte on end-of-WRITE with empty holder
    send_byte(8'hA5);
    tick(2);
    send_byte(8'h3C);
    tick(12);
    send_byte(8'h81);
    tick(57);
    // Arrives exactly on the timeout expiry cycle
    send_byte(8'h6E);
    tick(20);
    chk("no_gap_held", wr_cyc[16] - wr_cyc[15], 1);
    chk("no_gap_direct", wr_cyc[24] - wr_cyc[23], 1);
    chk("race_byte_accepted", wr_cyc[32] - wr_cyc[31], TIMEOUT_CYC + 1);
    chk("race_no_frame_err", ferr_seen, 0);
    chk("b2b_no_overrun", ovr_seen, 3);

    // Bytes 5..9, then silence -> timeout
    for (int k = 5; k < 10; k++) begin
      send_byte(8'(k * 17));
      tick(19);
    end
    f0 = ferr_seen;
    for (int i = 0; i < 300 && ferr_seen == f0; i++) @(negedge clk);
    chk("timeout_frame_err", ferr_seen, 1);
    chk("timeout_delay", ferr_cyc - wr_cyc[79], TIMEOUT_CYC + 1);
    chk("timeout_busy", {63'd0, ferr_busy}, 64'd0);
    chk("timeout_queue_empty", exp_q.size(), 0);
    pos = 0;
    tick(2);

    // New frame after timeout starts at addr 0; reset at byte 40 bit 3
    for (int k = 0; k <= 40; k++) begin
      send_byte(8'(k * 3 + 1));
      if (k != 40) tick(9);
    end
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk);
      if (bus.ram_we && bus.ram_addr == 10'd323) found = 1'b1;
    end
    chk("reset_point_reached", {63'd0, found}, 64'd1);
    #1;
    rst = 1'b1;
    exp_q.delete();
    pos = 0;
    @(negedge clk);
    chk("midframe_reset_outputs", {bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.start,
                                   bus.busy, bus.frame_err, bus.overrun}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick(2);

    // Full frame after reset
    for (int k = 0; k < NUM_BYTES; k++) begin
      send_byte(8'(k * 7) ^ 8'h55);
      tick(9);
    end
    wait_drain(200);
    chk("frame2_starts", starts_seen, exp_starts);
    chk("total_overrun", ovr_seen, 3);
    chk("total_frame_err", ferr_seen, 1);
    pulse_done();
    chk("busy_after_final_done", {63'd0, bus.busy}, 64'd0);
    tick(3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
